active_low_bus_initiator: RTL and testbench
===========================================

# active_low_bus_initiator

Host-side initiator for the active-low peripheral strobe interface. It accepts single read/write requests over a valid/ready port and drives `cs_n`, `we_n` and `oe_n` through a fixed setup/access/hold sequence. It waits for the peripheral's `ready_n`, samples `error_n`, and returns a response. It also turns the peripheral's `irq_n` into a sticky pending flag. It sits between the local request fabric and each active-low peripheral target.

## Interface
- `ADDR_W`, 8, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 15, maximum ACCESS cycles waiting for `ready_n` low; legal range 1..255
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  initiator can accept a request
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed
- `resp_rdata`  out  DATA_W  read data; 0 for writes
- `resp_error`  out  1  peripheral reported an error or the access timed out
- `resp_timeout`  out  1  access timed out
- `bus_cs_n`  out  1  chip select, active low
- `bus_we_n`  out  1  write enable, active low
- `bus_oe_n`  out  1  output enable, active low
- `bus_addr`  out  ADDR_W  latched address
- `bus_wdata`  out  DATA_W  latched write data
- `bus_rdata`  in  DATA_W  peripheral read data
- `bus_ready_n`  in  1  peripheral ready, active low
- `bus_error_n`  in  1  peripheral error, active low; valid with `bus_ready_n` = 0
- `bus_irq_n`  in  1  peripheral interrupt, active low
- `irq_pending`  out  1  sticky interrupt flag
- `irq_clr`  in  1  clears `irq_pending`

## Operation
- FSM states: IDLE → SETUP → ACCESS → HOLD → RESP → IDLE.
- **IDLE**
  - `req_ready` = 1; all strobes high.
  - On `req_valid`: latch write, addr and wdata into `bus_addr`, `bus_wdata` and an internal write flag; go to SETUP.
- **SETUP** (1 cycle): `cs_n` = 0, `we_n` = `oe_n` = 1.
- **ACCESS**
  - `cs_n` = 0; `we_n` = !write; `oe_n` = write.
  - Wait counter clears on entry.
  - If `bus_ready_n` = 0: capture `bus_rdata` (reads only; writes capture 0), set error = !`bus_error_n`, go to HOLD.
  - Else, if counter = TIMEOUT-1: set timeout = 1 and error = 1, go to HOLD.
  - Else: increment the counter.
  - `ready_n` low in the same cycle as the limit wins; no timeout is flagged.
- **HOLD** (1 cycle): `cs_n` = 0, `we_n` = `oe_n` = 1. This gives data hold before deselect.
- **RESP**
  - `resp_valid` = 1; all strobes high.
  - `resp_*` fields stay stable until `resp_valid & resp_ready`, then go to IDLE.
- `req_ready` is 0 outside IDLE. Only one access is outstanding at a time.
- `bus_addr` and `bus_wdata` hold their last latched value in every state.
- **Interrupt**
  - `bus_irq_n` is registered once.
  - `irq_pending` sets when the registered value goes 1→0, i.e. on a falling edge, not on level.
  - `irq_clr` clears it.
  - If set and clear happen in the same cycle, set wins.

## Timing
- All outputs are registered. Strobes take each state's values in the cycles the FSM occupies that state.
- **Reset values:**
  - strobes: `bus_cs_n` = `bus_we_n` = `bus_oe_n` = 1
  - bus latches: `bus_addr` = 0, `bus_wdata` = 0
  - handshake: `req_ready` = 1, `resp_valid` = 0
  - response fields: `resp_rdata` = 0, `resp_error` = 0, `resp_timeout` = 0
  - interrupt: `irq_pending` = 0
  - registered irq_n resets to 1.
- **Best-case latency** (accept at edge 0, `ready_n` low on the first ACCESS cycle):
  - SETUP in cycle 1
  - ACCESS in cycle 2
  - HOLD in cycle 3
  - `resp_valid` in cycle 4
- Each extra ACCESS cycle adds 1. Worst case `resp_valid` = cycle 3 + TIMEOUT.
- Back-to-back requests: `req_ready` rises the cycle after the response handshake, giving at least 1 IDLE cycle with all strobes high between accesses.
- Reset asserted mid-access: strobes return high at the next edge, the FSM goes to IDLE, and the pending response is discarded.

## Configuration
- Macro `ACTIVE_LOW_INIT_TIMEOUT_EN`.
- **Defined:** timeout counter present; behaviour as above.
- **Undefined:**
  - No counter; ACCESS waits indefinitely for `bus_ready_n` low.
  - `resp_timeout` is tied 0.
  - `TIMEOUT` is ignored.

## Test plan
- **Write, immediate ready:** write addr 0x3C, data 0xA5A5, `ready_n` low on the first ACCESS cycle, `error_n` = 1 → `cs_n` low for exactly 3 cycles, `we_n` low 1 cycle, `oe_n` stays 1; response at cycle 4 with error 0, rdata 0.
- **Read with wait states:** read addr 0x10, `ready_n` held high 4 ACCESS cycles then low with `bus_rdata` = 0x1234 → `oe_n` low 5 cycles, `resp_rdata` 0x1234, `resp_valid` at cycle 8.
- **Error and timeout:**
  - Access with `error_n` = 0 at ready → `resp_error` 1, `resp_timeout` 0.
  - With the macro defined, TIMEOUT = 15 and `ready_n` never low → ACCESS lasts 15 cycles; `resp_error` = `resp_timeout` = 1.
  - `ready_n` low exactly on cycle 15 → no timeout.
- **Backpressure:** hold `resp_ready` = 0 for 6 cycles → `resp_*` stable, `req_ready` 0, strobes high; a new `req_valid` is not accepted until after the handshake.
- **Interrupt:**
  - `bus_irq_n` falls → `irq_pending` 1 two edges later.
  - Held low → no re-set after `irq_clr`.
  - A new falling edge coinciding with `irq_clr` → `irq_pending` stays 1.
- **Reset mid-operation:** assert `rst` during ACCESS → next edge all strobes 1, `req_ready` 1, `resp_valid` 0, `irq_pending` 0.

Source files
------------

// File: rtl/active_low_bus_initiator.sv
// Single-access initiator for active-low strobe peripherals, with a sticky irq flag.
// Optional ACCESS timeout counter is enabled by ACTIVE_LOW_INIT_TIMEOUT_EN.
module active_low_bus_initiator #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              resp_timeout,
    output logic              bus_cs_n,
    output logic              bus_we_n,
    output logic              bus_oe_n,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready_n,
    input  logic              bus_error_n,
    input  logic              bus_irq_n,
    output logic              irq_pending,
    input  logic              irq_clr
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RESP
    } state_t;

    state_t state;
    logic   wr_q;
    logic   irq_q;
    logic   irq_q_d;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be within 1..255");
    end

`ifdef ACTIVE_LOW_INIT_TIMEOUT_EN
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       to_q;
    assign resp_timeout = to_q;
`else
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            bus_cs_n   <= 1'b1;
            bus_we_n   <= 1'b1;
            bus_oe_n   <= 1'b1;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            wr_q       <= 1'b0;
`ifdef ACTIVE_LOW_INIT_TIMEOUT_EN
            wait_cnt   <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        bus_addr  <= req_addr;
                        bus_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        bus_cs_n  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    bus_we_n <= ~wr_q;
                    bus_oe_n <= wr_q;
`ifdef ACTIVE_LOW_INIT_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // ready_n low takes priority over the timeout limit
                    if (!bus_ready_n) begin
                        resp_rdata <= wr_q ? '0 : bus_rdata;
                        resp_error <= ~bus_error_n;
`ifdef ACTIVE_LOW_INIT_TIMEOUT_EN
                        to_q       <= 1'b0;
`endif
                        bus_we_n   <= 1'b1;
                        bus_oe_n   <= 1'b1;
                        state      <= HOLD;
                    end
`ifdef ACTIVE_LOW_INIT_TIMEOUT_EN
                    else if (wait_cnt == LAST) begin
                        resp_rdata <= '0;
                        resp_error <= 1'b1;
                        to_q       <= 1'b1;
                        bus_we_n   <= 1'b1;
                        bus_oe_n   <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                HOLD: begin
                    bus_cs_n   <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Edge detect on the registered irq_n; a set in the same cycle beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q       <= 1'b1;
            irq_q_d     <= 1'b1;
            irq_pending <= 1'b0;
        end else begin
            irq_q       <= bus_irq_n;
            irq_q_d     <= irq_q;
            irq_pending <= (irq_q_d & ~irq_q) | (irq_pending & ~irq_clr);
        end
    end

endmodule

// File: tb/tb_active_low_bus_initiator.sv
// Scoreboard bench for active_low_bus_initiator: directed accesses, backpressure,
// interrupt edge handling and reset during an access.
module tb_active_low_bus_initiator;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_error;
    logic        resp_timeout;
    logic        bus_cs_n;
    logic        bus_we_n;
    logic        bus_oe_n;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ready_n;
    logic        bus_error_n;
    logic        bus_irq_n;
    logic        irq_pending;
    logic        irq_clr;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    active_low_bus_initiator #(
        .ADDR_W (8),
        .DATA_W (16),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .resp_timeout(resp_timeout),
        .bus_cs_n    (bus_cs_n),
        .bus_we_n    (bus_we_n),
        .bus_oe_n    (bus_oe_n),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ready_n (bus_ready_n),
        .bus_error_n (bus_error_n),
        .bus_irq_n   (bus_irq_n),
        .irq_pending (irq_pending),
        .irq_clr     (irq_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response per handshake
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                chk("resp_error", 32'(resp_error), 32'(e.err));
                chk("resp_timeout", 32'(resp_timeout), 32'(e.to));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wt = ACCESS cycles with ready_n high before it goes low; -1 = never
    task automatic run_access(input bit wr, input logic [7:0] a,
                              input logic [15:0] d, input int wt,
                              input logic [15:0] rd, input bit en,
                              input bit bp);
        int   c, ncs, nwe, noe, nacc, lat;
        exp_t e;
        bit   to;
        to   = (wt < 0);
        nacc = to ? TO : wt + 1;
        lat  = 3 + nacc;
        e.to    = to;
        e.err   = to | ~en;
        e.rdata = (wr || to) ? 16'h0 : rd;
        tick();
        chk("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        sb.push_back(e);
        resp_ready = !bp;
        c = 1;
        ncs = 0;
        nwe = 0;
        noe = 0;
        forever begin
            bus_ready_n = !(wt >= 0 && c == 2 + wt);
            bus_error_n = en;
            bus_rdata   = rd;
            @(negedge clk);
            if (resp_valid) break;
            if (!bus_cs_n) ncs++;
            if (!bus_we_n) nwe++;
            if (!bus_oe_n) noe++;
            if (c >= 60) begin
                chk("resp_valid_timeout", 32'd0, 32'd1);
                break;
            end
            tick();
            c++;
        end
        chk("resp_latency", 32'(c), 32'(lat));
        chk("cs_low_cycles", 32'(ncs), 32'(nacc + 2));
        chk("we_low_cycles", 32'(nwe), wr ? 32'(nacc) : 32'd0);
        chk("oe_low_cycles", 32'(noe), wr ? 32'd0 : 32'(nacc));
        chk("bus_addr", 32'(bus_addr), 32'(a));
        chk("bus_wdata", 32'(bus_wdata), 32'(d));
        if (bp) begin
            for (int i = 0; i < 6; i++) begin
                tick();
                bus_ready_n = 1'b1;
                req_valid   = 1'b1;
                req_write   = 1'b1;
                @(negedge clk);
                chk("bp_resp_valid", 32'(resp_valid), 32'd1);
                chk("bp_resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                chk("bp_req_ready", 32'(req_ready), 32'd0);
                chk("bp_strobes", 32'({bus_cs_n, bus_we_n, bus_oe_n}), 32'd7);
            end
            tick();
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        tick();
        bus_ready_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_strobes", 32'({bus_cs_n, bus_we_n, bus_oe_n}), 32'd7);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        resp_ready  = 1'b1;
        bus_rdata   = '0;
        bus_ready_n = 1'b1;
        bus_error_n = 1'b1;
        bus_irq_n   = 1'b1;
        irq_clr     = 1'b0;
        repeat (3) tick();
        chk("rst_strobes", 32'({bus_cs_n, bus_we_n, bus_oe_n}), 32'd7);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fields",
            32'({resp_rdata, resp_error, resp_timeout}), 32'd0);
        chk("rst_irq_pending", 32'(irq_pending), 32'd0);
        rst = 1'b0;

        run_access(1'b1, 8'h3C, 16'hA5A5, 0, 16'hBEEF, 1'b1, 1'b0);
        run_access(1'b0, 8'h10, 16'h0000, 4, 16'h1234, 1'b1, 1'b0);
        run_access(1'b0, 8'h20, 16'h0001, 1, 16'h5555, 1'b0, 1'b0);
`ifdef ACTIVE_LOW_INIT_TIMEOUT_EN
        run_access(1'b0, 8'h44, 16'h0002, -1, 16'h7777, 1'b1, 1'b0);
        run_access(1'b0, 8'h45, 16'h0003, TO - 1, 16'h9ABC, 1'b1, 1'b0);
`endif
        run_access(1'b1, 8'h81, 16'h0F0F, 2, 16'h0000, 1'b1, 1'b1);
        run_access(1'b0, 8'hFF, 16'hFFFF, 0, 16'hCAFE, 1'b1, 1'b0);

        // interrupt: falling edge sets two edges later
        bus_irq_n = 1'b0;
        tick();
        chk("irq_one_edge", 32'(irq_pending), 32'd0);
        tick();
        chk("irq_two_edges", 32'(irq_pending), 32'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", 32'(irq_pending), 32'd0);
        repeat (4) tick();
        chk("irq_level_no_reset", 32'(irq_pending), 32'd0);
        bus_irq_n = 1'b1;
        repeat (3) tick();
        bus_irq_n = 1'b0;
        repeat (2) tick();
        chk("irq_second_fall", 32'(irq_pending), 32'd1);
        bus_irq_n = 1'b1;
        repeat (3) tick();
        bus_irq_n = 1'b0;
        tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_set_beats_clr", 32'(irq_pending), 32'd1);
        bus_irq_n = 1'b1;

        // reset during ACCESS discards the access
        tick();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h55;
        tick();
        req_valid   = 1'b0;
        bus_ready_n = 1'b1;
        tick();
        tick();
        chk("pre_rst_oe_n", 32'(bus_oe_n), 32'd0);
        chk("pre_rst_irq", 32'(irq_pending), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_strobes", 32'({bus_cs_n, bus_we_n, bus_oe_n}), 32'd7);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_irq", 32'(irq_pending), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
